// File: rtl/exe_divider.sv
// Iterative restoring divider for DIV/DIVU: quotient to LO, remainder to HI, one bit per cycle.
// 33 stall cycles from start to DONE; results held in DONE while StallOtherE is high.
module exe_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       isDivE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             FlushE,
  input  logic             StallOtherE,
  output logic             DivStallE,
  output logic             DivValidE,
  output logic [WIDTH-1:0] DivHiE,
  output logic [WIDTH-1:0] DivLoE
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] origA;
  logic [CW-1:0]    count;
  logic             negQ;
  logic             negR;
  logic             divZero;

  logic             isSigned;
  logic             start;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qBit;
  logic [WIDTH-1:0] nextRem;
  logic [WIDTH-1:0] nextQuo;
  logic [WIDTH-1:0] finalLo;
  logic [WIDTH-1:0] finalHi;

  always_comb begin
    isSigned = (isDivE == 2'b01);
    start    = (state == IDLE) && ((isDivE == 2'b01) || (isDivE == 2'b10)) && !FlushE && !reset;
    absA     = (isSigned && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
    absB     = (isSigned && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
    // The 33-bit trial subtract's top bit is the borrow: clear means the divisor fits.
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    qBit     = !trial[WIDTH];
    nextRem  = qBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    nextQuo  = {quo[WIDTH-2:0], qBit};
    finalLo  = divZero ? '1    : (negQ ? -nextQuo : nextQuo);
    finalHi  = divZero ? origA : (negR ? -nextRem : nextRem);
    DivStallE = start || (state == BUSY);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rem       <= '0;
      quo       <= '0;
      divisor   <= '0;
      origA     <= '0;
      count     <= '0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      divZero   <= 1'b0;
      DivValidE <= 1'b0;
      DivHiE    <= '0;
      DivLoE    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            divisor <= absB;
            quo     <= absA;
            rem     <= '0;
            count   <= '0;
            negQ    <= isSigned && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
            negR    <= isSigned && SrcAE[WIDTH-1];
            origA   <= SrcAE;
            divZero <= (SrcBE == '0);
            state   <= BUSY;
          end else if (FlushE) begin
            DivValidE <= 1'b0;
            DivHiE    <= '0;
            DivLoE    <= '0;
          end
        end
        BUSY: begin
          if (FlushE) begin
            state     <= IDLE;
            DivValidE <= 1'b0;
            DivHiE    <= '0;
            DivLoE    <= '0;
          end else begin
            rem   <= nextRem;
            quo   <= nextQuo;
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) begin
              DivLoE    <= finalLo;
              DivHiE    <= finalHi;
              DivValidE <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (FlushE) begin
            state     <= IDLE;
            DivValidE <= 1'b0;
            DivHiE    <= '0;
            DivLoE    <= '0;
          end else if (!StallOtherE) begin
            state     <= IDLE;
            DivValidE <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_divider.sv
// Self-checking bench for exe_divider: directed vectors, randomized divides against a
// plain-arithmetic model, and hand sequences for hold, flush and async reset.
module tb_exe_divider;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  isDivE = 2'b00;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        FlushE = 1'b0;
  logic        StallOtherE = 1'b0;
  logic        DivStallE;
  logic        DivValidE;
  logic [31:0] DivHiE;
  logic [31:0] DivLoE;

  int checks = 0;
  int failures = 0;

  exe_divider #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .isDivE(isDivE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .FlushE(FlushE), .StallOtherE(StallOtherE), .DivStallE(DivStallE),
    .DivValidE(DivValidE), .DivHiE(DivHiE), .DivLoE(DivLoE)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Result from the instruction semantics: {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (op == 2'b10) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    sa = $signed(a);
    sb = $signed(b);
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  // Entered just after the start has been driven in the cycle-0 low phase.
  task automatic waitDone(output int lat, output int stalls);
    lat = -1;
    stalls = DivStallE ? 1 : 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      SrcAE = $urandom;
      SrcBE = $urandom;
      if (DivValidE) begin
        lat = i;
        break;
      end
      if (DivStallE) stalls++;
    end
  endtask

  task automatic doDiv(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eLo, input logic [31:0] eHi);
    int lat, stalls;
    isDivE = op;
    SrcAE = a;
    SrcBE = b;
    #1;
    waitDone(lat, stalls);
    chk({tag, "_latency"}, lat, 33);
    chk({tag, "_stalls"}, stalls, 33);
    chk({tag, "_lo"}, DivLoE, eLo);
    chk({tag, "_hi"}, DivHiE, eHi);
    chk({tag, "_stall_done"}, {31'd0, DivStallE}, 0);
    isDivE = 2'b00;
    @(negedge clock);
  endtask

  task automatic watchNoValid(input string name);
    int seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (DivValidE) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    vec_t vecs[9];
    logic [63:0] e;
    logic [1:0]  op;
    logic [31:0] a, b;
    int lat, stalls;

    vecs[0] = '{2'b10, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{2'b01, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
    vecs[2] = '{2'b01, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h0};
    vecs[3] = '{2'b10, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234};
    vecs[4] = '{2'b01, 32'hFFFFFFF6,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF6};
    vecs[5] = '{2'b10, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'h0};
    vecs[6] = '{2'b01, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
    vecs[7] = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'h0,          32'h80000000};
    vecs[8] = '{2'b01, 32'hFFFFFFF8,   32'hFFFFFFFD,   32'd2,          32'hFFFFFFFE};

    #2 reset = 1'b1;
    #1;
    chk("reset_stall", {31'd0, DivStallE}, 0);
    chk("reset_valid", {31'd0, DivValidE}, 0);
    chk("reset_hi", DivHiE, 0);
    chk("reset_lo", DivLoE, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    foreach (vecs[i]) doDiv($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(1, 2));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      e = model(op, a, b);
      doDiv($sformatf("rnd%0d", i), op, a, b, e[31:0], e[63:32]);
    end

    // DONE held by another hazard, then back-to-back restart with isDivE still DIV.
    isDivE = 2'b01;
    SrcAE = 32'hFFFFFF9C;
    SrcBE = 32'd7;
    #1;
    waitDone(lat, stalls);
    chk("hold_latency", lat, 33);
    StallOtherE = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk($sformatf("hold_valid%0d", k), {31'd0, DivValidE}, 1);
      chk($sformatf("hold_stall%0d", k), {31'd0, DivStallE}, 0);
      chk($sformatf("hold_lo%0d", k), DivLoE, 32'hFFFFFFF2);
      chk($sformatf("hold_hi%0d", k), DivHiE, 32'hFFFFFFFE);
    end
    StallOtherE = 1'b0;
    @(negedge clock);
    SrcAE = 32'd1000;
    SrcBE = 32'hFFFFFFFD;
    #1;
    chk("release_valid", {31'd0, DivValidE}, 0);
    chk("restart_stall", {31'd0, DivStallE}, 1);
    e = model(2'b01, 32'd1000, 32'hFFFFFFFD);
    waitDone(lat, stalls);
    chk("restart_latency", lat, 33);
    chk("restart_stalls", stalls, 33);
    chk("restart_lo", DivLoE, e[31:0]);
    chk("restart_hi", DivHiE, e[63:32]);
    isDivE = 2'b00;
    @(negedge clock);

    // Flush in BUSY cycle 10.
    isDivE = 2'b10;
    SrcAE = 32'd5000;
    SrcBE = 32'd3;
    repeat (10) @(negedge clock);
    FlushE = 1'b1;
    isDivE = 2'b00;
    @(negedge clock);
    chk("flush_busy_stall", {31'd0, DivStallE}, 0);
    chk("flush_busy_valid", {31'd0, DivValidE}, 0);
    chk("flush_busy_lo", DivLoE, 0);
    chk("flush_busy_hi", DivHiE, 0);
    FlushE = 1'b0;
    watchNoValid("flush_busy_novalid");

    // Flush colliding with a start in IDLE.
    isDivE = 2'b01;
    SrcAE = 32'd50;
    SrcBE = 32'd5;
    FlushE = 1'b1;
    #1;
    chk("flush_idle_stall0", {31'd0, DivStallE}, 0);
    @(negedge clock);
    chk("flush_idle_stall1", {31'd0, DivStallE}, 0);
    FlushE = 1'b0;
    isDivE = 2'b00;
    watchNoValid("flush_idle_novalid");

    // Async reset in the middle of BUSY, with earlier results still on HI/LO.
    doDiv("pre_reset", 2'b10, 32'd100, 32'd7, 32'd14, 32'd2);
    isDivE = 2'b01;
    SrcAE = 32'd1000;
    SrcBE = 32'd7;
    repeat (20) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("areset_stall", {31'd0, DivStallE}, 0);
    chk("areset_valid", {31'd0, DivValidE}, 0);
    chk("areset_hi", DivHiE, 0);
    chk("areset_lo", DivLoE, 0);
    @(negedge clock);
    isDivE = 2'b00;
    reset = 1'b0;
    watchNoValid("areset_novalid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
